ram_bist_ctrl: RTL and testbench

Built-in self-test controller that drives the asynchronous dual-port RAM (`asy_dual_port_ram`) from its write and read ports. It writes a deterministic address-derived pattern to every location, reads every location back, and compares each read against the expected value. It reports pass/fail, the mismatch count and the first failing address. It sits beside the RAM and is the initiator for the RAM's write and read ports.

---
 rtl/ram_bist_pkg.sv | 19 +
 rtl/ram_bist_cmp.sv | 28 ++
 rtl/ram_bist_ctrl.sv | 98 +++++++++
 tb/tb_ram_bist_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: FSM states and pattern function for ram_bist_ctrl; BIST_INVERT_PASS_EN adds the inverted-pass states
package ram_bist_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
`ifdef BIST_INVERT_PASS_EN
    , S_WRITE_INV,
    S_READ_INV
`endif
  } state_t;
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic [31:0] addr,
                                      input logic [31:0] step, input logic invert);
    logic [31:0] p;
    p = seed + addr * step;
    return invert ? ~p : p;
  endfunction
endpackage

// File: rtl/ram_bist_cmp.sv
// ram_bist_cmp: read-data comparator with saturating error counter and first-fail address capture
module ram_bist_cmp import ram_bist_pkg::*; #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_en,
  input  logic [ADDR_SIZE-1:0] i_addr,
  input  logic [DATA_SIZE-1:0] i_rd_data,
  input  logic [DATA_SIZE-1:0] i_exp,
  output logic                 o_mismatch,
  output logic [ADDR_SIZE+1:0] o_err_count,
  output logic [ADDR_SIZE-1:0] o_fail_addr
);
  assign o_mismatch = i_en && (i_rd_data != i_exp);
  // count mismatches (saturating) and latch the address of the first one
  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      o_err_count <= '0;
      o_fail_addr <= '0;
    end else if (o_mismatch) begin
      o_err_count <= (&o_err_count) ? o_err_count : o_err_count + 1'b1;
      if (o_err_count == '0) o_fail_addr <= i_addr;
    end
  end
endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: RAM BIST FSM and address counter; define BIST_INVERT_PASS_EN to add an inverted-pattern write/read pass
module ram_bist_ctrl import ram_bist_pkg::*; #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8,
  parameter int PAT_STEP  = 37
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [DATA_SIZE-1:0] i_seed,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [ADDR_SIZE+1:0] o_err_count,
  output logic [ADDR_SIZE-1:0] o_fail_addr,
  output logic                 o_ram_wr_en,
  output logic [ADDR_SIZE-1:0] o_ram_wr_addr,
  output logic [DATA_SIZE-1:0] o_ram_wr_data,
  output logic                 o_ram_rd_en,
  output logic [ADDR_SIZE-1:0] o_ram_rd_addr,
  input  logic [DATA_SIZE-1:0] i_ram_rd_data
);
  state_t               r_state, w_state_next;
  logic [ADDR_SIZE-1:0] r_addr;
  logic [DATA_SIZE-1:0] r_seed, w_pat;
  logic [ADDR_SIZE+1:0] w_err_count;
  logic                 r_pass, w_last, w_start_ok, w_wr_phase, w_rd_phase, w_inv, w_mismatch;
  assign w_last     = &r_addr;
  assign w_start_ok = (r_state == S_IDLE) && i_start && !i_abort;
`ifdef BIST_INVERT_PASS_EN
  assign w_wr_phase = (r_state == S_WRITE) || (r_state == S_WRITE_INV);
  assign w_rd_phase = (r_state == S_READ) || (r_state == S_READ_INV);
  assign w_inv      = (r_state == S_WRITE_INV) || (r_state == S_READ_INV);
`else
  assign w_wr_phase = r_state == S_WRITE;
  assign w_rd_phase = r_state == S_READ;
  assign w_inv      = 1'b0;
`endif
  assign w_pat       = DATA_SIZE'(pat(32'(r_seed), 32'(r_addr), 32'(PAT_STEP), w_inv));
  assign o_pass      = r_pass;
  assign o_err_count = w_err_count;
  // state register
  always_ff @(posedge i_clk) begin
    r_state <= !i_reset ? S_IDLE : w_state_next;
  end
  // next-state logic and RAM/status outputs; abort overrides every transition
  always_comb begin
    w_state_next  = r_state;
    o_busy        = w_wr_phase || w_rd_phase;
    o_done        = r_state == S_DONE;
    o_ram_wr_en   = w_wr_phase;
    o_ram_wr_addr = w_wr_phase ? r_addr : '0;
    o_ram_wr_data = w_wr_phase ? w_pat : '0;
    o_ram_rd_en   = w_rd_phase;
    o_ram_rd_addr = w_rd_phase ? r_addr : '0;
    case (r_state)
      S_IDLE:      w_state_next = i_start ? S_WRITE : S_IDLE;
      S_WRITE:     w_state_next = w_last ? S_READ : S_WRITE;
`ifdef BIST_INVERT_PASS_EN
      S_READ:      w_state_next = w_last ? S_WRITE_INV : S_READ;
      S_WRITE_INV: w_state_next = w_last ? S_READ_INV : S_WRITE_INV;
      S_READ_INV:  w_state_next = w_last ? S_DONE : S_READ_INV;
`else
      S_READ:      w_state_next = w_last ? S_DONE : S_READ;
`endif
      default:     w_state_next = S_IDLE;
    endcase
    if (i_abort) w_state_next = S_IDLE;
  end
  // address counter: cleared on start/abort, steps every write/read cycle and wraps between passes
  always_ff @(posedge i_clk) begin
    if (!i_reset || w_start_ok || i_abort) r_addr <= '0;
    else if (w_wr_phase || w_rd_phase) r_addr <= r_addr + 1'b1;
  end
  // seed captured when a start is accepted
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_seed <= '0;
    else if (w_start_ok) r_seed <= i_seed;
  end
  // pass verdict formed on entry to DONE, folding in the final compare
  always_ff @(posedge i_clk) begin
    if (!i_reset || w_start_ok || i_abort) r_pass <= 1'b0;
    else if (w_state_next == S_DONE) r_pass <= (w_err_count == '0) && !w_mismatch;
  end
  ram_bist_cmp #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) u_cmp (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_start_ok),
    .i_en        (w_rd_phase && !i_abort),
    .i_addr      (r_addr),
    .i_rd_data   (i_ram_rd_data),
    .i_exp       (w_pat),
    .o_mismatch  (w_mismatch),
    .o_err_count (w_err_count),
    .o_fail_addr (o_fail_addr)
  );
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: bench for ram_bist_ctrl with a behavioural RAM, fault injection and a cycle-index model (BIST_INVERT_PASS_EN aware)
module tb_ram_bist_ctrl;
  localparam int N = 16;
`ifdef BIST_INVERT_PASS_EN
  localparam bit INV = 1'b1;
  localparam int L = 4 * N + 1;
`else
  localparam bit INV = 1'b0;
  localparam int L = 2 * N + 1;
`endif
  logic       clk, rst_n, start, abort;
  logic [7:0] seed, wr_data, rd_data;
  logic       busy, done, pass, wr_en, rd_en;
  logic [5:0] err_count;
  logic [3:0] fail_addr, wr_addr, rd_addr;
  logic [7:0] mem [N];
  logic [7:0] fault [N];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_t = 0, m_err = 0, m_fail = 0;
  bit m_pass = 0, m_valid = 0;
  logic [7:0] m_seed = 0;

  ram_bist_ctrl dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_abort(abort), .i_seed(seed),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_count(err_count), .o_fail_addr(fail_addr),
    .o_ram_wr_en(wr_en), .o_ram_wr_addr(wr_addr), .o_ram_wr_data(wr_data),
    .o_ram_rd_en(rd_en), .o_ram_rd_addr(rd_addr), .i_ram_rd_data(rd_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr] ^ fault[rd_addr];

  function automatic bit is_wr(int t);
    return (t >= 1 && t <= N) || (INV && t > 2 * N && t <= 3 * N);
  endfunction
  function automatic bit is_rd(int t);
    return (t > N && t <= 2 * N) || (INV && t > 3 * N && t <= 4 * N);
  endfunction
  function automatic int addr_of(int t);
    return (t - 1) % N;
  endfunction
  function automatic int pat_of(int t, logic [7:0] s);
    int p;
    p = (s + addr_of(t) * 37) % 256;
    return (t > 2 * N) ? (255 - p) : p;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // model: test progress expressed as cycles since the accepted start
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1; m_t = 0; m_seed = 0; m_err = 0; m_fail = 0; m_pass = 0;
    end else if (abort) begin
      m_t = 0; m_pass = 0;
    end else if (m_t == 0) begin
      if (start) begin
        m_t = 1; m_seed = seed; m_err = 0; m_fail = 0; m_pass = 0;
      end
    end else begin
      if (is_rd(m_t) && fault[addr_of(m_t)] != 0) begin
        if (m_err == 0) m_fail = addr_of(m_t);
        m_err++;
      end
      if (m_t == L - 1) m_pass = (m_err == 0);
      m_t = (m_t == L) ? 0 : m_t + 1;
    end
  end

  // per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("busy", busy, int'(is_wr(m_t) || is_rd(m_t)));
      chk("done", done, int'(m_t == L));
      chk("pass", pass, int'(m_pass));
      chk("err_count", err_count, m_err);
      chk("fail_addr", fail_addr, m_fail);
      chk("wr_en", wr_en, int'(is_wr(m_t)));
      chk("wr_addr", wr_addr, is_wr(m_t) ? addr_of(m_t) : 0);
      chk("wr_data", wr_data, is_wr(m_t) ? pat_of(m_t, m_seed) : 0);
      chk("rd_en", rd_en, int'(is_rd(m_t)));
      chk("rd_addr", rd_addr, is_rd(m_t) ? addr_of(m_t) : 0);
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
    cyc++;
  endtask
  task automatic launch(input logic [7:0] s);
    start = 1; seed = s;
    step();
    start = 0;
    cyc = 1;
  endtask
  task automatic finish_test(input string tag, input int e_err, input int e_fail, input int e_pass);
    while (!done && cyc < L + 10) step();
    chk({tag, "_done_latency"}, cyc, L);
    chk({tag, "_err"}, err_count, e_err);
    chk({tag, "_fail_addr"}, fail_addr, e_fail);
    chk({tag, "_pass"}, pass, e_pass);
    step();
  endtask
  task automatic clear_faults();
    for (int i = 0; i < N; i++) fault[i] = 8'h00;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    clear_faults();
    rst_n = 0; start = 0; abort = 0; seed = 0;
    repeat (3) step();
    chk("reset_busy", busy, 0);
    chk("reset_wr_data", wr_data, 0);
    rst_n = 1;
    step();
    // clean RAM, seed 0
    launch(8'h00);
    chk("t1_wr_addr0", wr_addr, 0);
    chk("t1_wr_data0", wr_data, 0);
    step();
    chk("t1_wr_data1", wr_data, 37);
    while (cyc < 16) step();
    chk("t1_wr_data15", wr_data, 43);
`ifdef BIST_INVERT_PASS_EN
    while (cyc < 34) step();
    chk("t1_inv_wr_addr1", wr_addr, 1);
    chk("t1_inv_wr_data1", wr_data, 8'hDA);
`endif
    finish_test("clean", 0, 0, 1);
    // stuck bit 0 at address 5
    fault[5] = 8'h01;
    launch(8'h10);
    finish_test("stuck", INV ? 2 : 1, 5, 0);
    clear_faults();
    // two corrupted addresses
    fault[3] = 8'h80; fault[9] = 8'h04;
    launch(8'h2C);
    finish_test("multi", INV ? 4 : 2, 3, 0);
    clear_faults();
    // clean run with a start pulse mid-test that must be ignored
    launch(8'hC3);
    while (cyc < 10) step();
    start = 1; seed = 8'hFF;
    step();
    start = 0;
    finish_test("restart_ignored", 0, 0, 1);
    // start together with abort in IDLE: abort wins
    start = 1; abort = 1;
    step();
    start = 0; abort = 0;
    chk("start_abort_busy", busy, 0);
    // abort at write address 7
    launch(8'h33);
    while (wr_addr != 4'd7 && cyc < 20) step();
    chk("abort_at_addr", wr_addr, 7);
    abort = 1;
    step();
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_pass", pass, 0);
    repeat (40) step();
    // reset mid-READ after a mismatch has been logged
    fault[2] = 8'h10;
    launch(8'h55);
    while (cyc < 20) step();
    chk("pre_reset_rd_en", rd_en, 1);
    chk("pre_reset_err", err_count, 1);
    rst_n = 0;
    step();
    rst_n = 1;
    clear_faults();
    chk("post_reset_busy", busy, 0);
    chk("post_reset_rd_en", rd_en, 0);
    chk("post_reset_err", err_count, 0);
    chk("post_reset_fail", fail_addr, 0);
    step();
    launch(8'hA5);
    finish_test("after_reset", 0, 0, 1);
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
